// File: rtl/auo_delta_timing_gen_if.sv
// Pixel source handshake bundle for auo_delta_timing_gen.
// Latency: none; plain wires.
// Backpressure: the consumer raises pix_ready for one clk_in cycle per pixel it takes.
// Signals: pix_rgb {R,G,B}, pix_valid (source has a pixel), pix_ready (consumer takes it).
interface auo_delta_timing_gen_if #(
  parameter int DW = 8
);
  logic [3*DW-1:0] pix_rgb;
  logic            pix_valid;
  logic            pix_ready;

  modport master (output pix_rgb, output pix_valid, input pix_ready);
  modport slave  (input pix_rgb, input pix_valid, output pix_ready);
endinterface

// File: rtl/auo_delta_timing_gen.sv
// Timing generator + subpixel serialiser for serial-RGB delta-stripe LCD panels.
// Latency: outputs lag the h/v counters by one pixel tick; a fetched pixel drives rgb on its fetch tick.
// Backpressure: none toward the panel; a missing pixel at fetch is replaced by black and flagged.
// Ports: clk_in (2x pixel rate), rst_n (sync, active low), mode (0/3 stream, 1 gradient,
//        2 solid), pix (source handshake, slave side), rgb/hsync/vsync/pclk/de to the panel,
//        field (toggles per frame), underflow (sticky missed-pixel flag).
module auo_delta_timing_gen #(
  parameter int              DW          = 8,
  parameter int              H_TOTAL     = 1716,
  parameter int              V_TOTAL     = 263,
  parameter int              HSYNC_W     = 1,
  parameter int              VSYNC_W     = 1,
  parameter int              H_ACT_START = 167,
  parameter int              H_ACT_LEN   = 768,
  parameter int              V_ACT_START = 29,
  parameter int              V_ACT_LEN   = 226,
  parameter logic [DW-1:0]   BLANK_LVL   = 8'hFF,
  parameter logic [3*DW-1:0] SOLID_RGB   = 24'h00FF80
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  auo_delta_timing_gen_if.slave  pix,
  output logic [DW-1:0]          rgb,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   pclk,
  output logic                   de,
  output logic                   field,
  output logic                   underflow
);

  // One extra bit so that start+len never wraps when it equals the total.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_SW   = HW'(HSYNC_W);
  localparam logic [VW-1:0] V_SW   = VW'(VSYNC_W);
  localparam logic [HW-1:0] H_AS   = HW'(H_ACT_START);
  localparam logic [HW-1:0] H_AE   = HW'(H_ACT_START + H_ACT_LEN);
  localparam logic [VW-1:0] V_AS   = VW'(V_ACT_START);
  localparam logic [VW-1:0] V_AE   = VW'(V_ACT_START + V_ACT_LEN);

  logic [HW-1:0]   hcount;
  logic [VW-1:0]   vcount;
  logic [1:0]      slot;
  logic [DW-1:0]   pix_cnt;
  logic [3*DW-1:0] held;
  logic [1:0]      mode_l;

  logic            tick;
  logic            h_wrap;
  logic            v_wrap;
  logic            act_line;
  logic            act_col;
  logic            active;
  logic            stream;
  logic            fetch;
  logic [1:0]      slot_cur;
  logic [3*DW-1:0] cur_pix;
  logic [DW-1:0]   sub_r;
  logic [DW-1:0]   sub_g;
  logic [DW-1:0]   sub_b;
  logic [DW-1:0]   sub;

  // Pixel-domain state moves on the clk_in edge where pclk falls.
  assign tick     = pclk;
  assign h_wrap   = (hcount == H_LAST);
  assign v_wrap   = (vcount == V_LAST);
  assign act_line = (vcount >= V_AS) && (vcount < V_AE);
  assign act_col  = (hcount >= H_AS) && (hcount < H_AE);
  assign active   = act_line && act_col;
  assign stream   = (mode_l == 2'd0) || (mode_l == 2'd3);

  // The slot is forced to 0 at the first active column so a line always starts on slot 0.
  assign slot_cur = (hcount == H_AS) ? 2'd0 : slot;

  assign fetch         = tick && active && (slot_cur == 2'd0) && stream;
  assign pix.pix_ready = fetch;

  always_comb begin
    cur_pix = held;
    case (mode_l)
      2'd1:    cur_pix = {3{pix_cnt}};
      2'd2:    cur_pix = SOLID_RGB;
      default: begin
        // On the fetch tick the incoming pixel is shown directly, not the stale held one.
        if (fetch) cur_pix = pix.pix_valid ? pix.pix_rgb : '0;
        else       cur_pix = held;
      end
    endcase
  end

  assign sub_r = cur_pix[3*DW-1:2*DW];
  assign sub_g = cur_pix[2*DW-1:DW];
  assign sub_b = cur_pix[DW-1:0];

  // Odd lines rotate the order to B,R,G to follow the delta subpixel layout.
  always_comb begin
    sub = sub_b;
    case (slot_cur)
      2'd0:    sub = vcount[0] ? sub_b : sub_r;
      2'd1:    sub = vcount[0] ? sub_r : sub_g;
      default: sub = vcount[0] ? sub_g : sub_b;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      pclk      <= 1'b0;
      rgb       <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      de        <= 1'b0;
      field     <= 1'b0;
      underflow <= 1'b0;
      hcount    <= '0;
      vcount    <= '0;
      slot      <= 2'd0;
      pix_cnt   <= '0;
      held      <= '0;
      mode_l    <= 2'd0;
    end else begin
      pclk <= ~pclk;
      if (tick) begin
        hsync <= !(hcount < H_SW);
        vsync <= !(vcount < V_SW);
        de    <= active;
        if (!act_line)    rgb <= BLANK_LVL;
        else if (act_col) rgb <= sub;
        else              rgb <= '0;

        if (fetch) begin
          held <= pix.pix_valid ? pix.pix_rgb : '0;
          if (!pix.pix_valid) underflow <= 1'b1;
        end

        if (active) slot <= (slot_cur == 2'd2) ? 2'd0 : slot_cur + 2'd1;

        if (h_wrap)                           pix_cnt <= '0;
        else if (active && slot_cur == 2'd2)  pix_cnt <= pix_cnt + 1'b1;

        if (h_wrap) begin
          hcount <= '0;
          if (v_wrap) begin
            vcount <= '0;
            field  <= ~field;
            mode_l <= mode;
          end else begin
            vcount <= vcount + 1'b1;
          end
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_auo_delta_timing_gen.sv
// Directed bench for auo_delta_timing_gen on a small 12x5 raster.
// Latency: each step covers one pixel tick (two clk_in cycles).
// Backpressure: the bench acts as an always-present source except where a vector drops pix_valid.
module tb_auo_delta_timing_gen;
  localparam int HT = 12;
  localparam int VT = 5;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] mode   = 2'd0;
  logic [7:0] rgb;
  logic       hsync, vsync, pclk, de, field, underflow;

  auo_delta_timing_gen_if #(.DW(8)) pif ();

  auo_delta_timing_gen #(
    .DW(8), .H_TOTAL(HT), .V_TOTAL(VT), .HSYNC_W(2), .VSYNC_W(1),
    .H_ACT_START(3), .H_ACT_LEN(6), .V_ACT_START(1), .V_ACT_LEN(3),
    .BLANK_LVL(8'hFF), .SOLID_RGB(24'h00FF80)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .mode(mode), .pix(pif),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .pclk(pclk),
    .de(de), .field(field), .underflow(underflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         fr, h, v;
    logic [1:0] md;
    logic       vd;
    logic [23:0] px;
    logic [7:0] e_rgb;
    logic       e_hs, e_vs, e_de, e_rdy, e_fld, e_uf;
  } vec_t;

  vec_t vecs[$];
  vec_t rvecs[$];

  int errors = 0;
  int checks = 0;
  int cur_h = 0, cur_v = 0, cur_fr = 0;
  int pclk_bad = 0, rdy_bad = 0;
  int rdy_cnt[8];
  logic       s_rdy, s_hs, s_vs, s_de, s_fld, s_uf;
  logic [7:0] s_rgb;

  function automatic vec_t mk(int fr, int h, int v, logic [1:0] md, logic vd, logic [23:0] px,
                              logic [7:0] rg, logic hs, logic vs, logic d, logic rdy,
                              logic fld, logic uf);
    vec_t t;
    t.fr = fr; t.h = h; t.v = v; t.md = md; t.vd = vd; t.px = px;
    t.e_rgb = rg; t.e_hs = hs; t.e_vs = vs; t.e_de = d; t.e_rdy = rdy; t.e_fld = fld; t.e_uf = uf;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One pixel tick: the pclk-high cycle (pix_ready visible), then the tick edge.
  task automatic step();
    @(posedge clk_in); #1;
    if (pclk !== 1'b1) pclk_bad++;
    s_rdy = pif.pix_ready;
    if (s_rdy === 1'b1 && cur_fr < 8) rdy_cnt[cur_fr]++;
    @(posedge clk_in); #1;
    if (pclk !== 1'b0) pclk_bad++;
    if (pif.pix_ready !== 1'b0) rdy_bad++;
    s_rgb = rgb; s_hs = hsync; s_vs = vsync; s_de = de; s_fld = field; s_uf = underflow;
    if (cur_h == HT - 1) begin
      cur_h = 0;
      if (cur_v == VT - 1) begin cur_v = 0; cur_fr++; end
      else cur_v++;
    end else cur_h++;
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    int guard;
    mode = t.md; pif.pix_valid = t.vd; pif.pix_rgb = t.px;
    guard = 0;
    while (!(cur_fr == t.fr && cur_h == t.h && cur_v == t.v) && guard < 1000) begin
      step();
      guard++;
    end
    if (guard >= 1000) begin
      checks++; errors++;
      $display("FAIL %s walk: position f%0d h%0d v%0d never reached", tag, t.fr, t.h, t.v);
    end else begin
      step();
      chk({tag, " rgb"},       32'(s_rgb), 32'(t.e_rgb));
      chk({tag, " hsync"},     32'(s_hs),  32'(t.e_hs));
      chk({tag, " vsync"},     32'(s_vs),  32'(t.e_vs));
      chk({tag, " de"},        32'(s_de),  32'(t.e_de));
      chk({tag, " pix_ready"}, 32'(s_rdy), 32'(t.e_rdy));
      chk({tag, " field"},     32'(s_fld), 32'(t.e_fld));
      chk({tag, " underflow"}, 32'(s_uf),  32'(t.e_uf));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pclk"},      32'(pclk),          32'd0);
    chk({tag, " rgb"},       32'(rgb),           32'd0);
    chk({tag, " hsync"},     32'(hsync),         32'd1);
    chk({tag, " vsync"},     32'(vsync),         32'd1);
    chk({tag, " de"},        32'(de),            32'd0);
    chk({tag, " field"},     32'(field),         32'd0);
    chk({tag, " underflow"}, 32'(underflow),     32'd0);
    chk({tag, " pix_ready"}, 32'(pif.pix_ready), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] p, q, r;
    p = 24'h112233; q = 24'hA1B2C3; r = 24'h445566;
    for (int i = 0; i < 8; i++) rdy_cnt[i] = 0;

    // Frame 0: stream (mode latched 0 by reset); mode input goes to 1 mid-frame.
    vecs.push_back(mk(0, 0, 0, 0, 1, p, 8'hFF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, p, 8'hFF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2, 0, 0, 1, p, 8'hFF, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,11, 0, 0, 1, p, 8'hFF, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, p, 8'h00, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2, 1, 0, 1, p, 8'h00, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 1, p, 8'h33, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4, 1, 0, 1, p, 8'h11, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 5, 1, 0, 1, p, 8'h22, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 6, 1, 0, 1, p, 8'h33, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8, 1, 0, 1, p, 8'h22, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 9, 1, 0, 1, p, 8'h00, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3, 2, 0, 1, p, 8'h11, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4, 2, 1, 1, p, 8'h22, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 5, 2, 1, 1, p, 8'h33, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 7, 2, 1, 1, p, 8'h22, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8, 2, 1, 1, p, 8'h33, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 5, 3, 1, 1, p, 8'h22, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4, 1, 1, p, 8'hFF, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 4, 1, 1, p, 8'hFF, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0,11, 4, 1, 1, p, 8'hFF, 1, 1, 0, 0, 1, 0));
    // Frame 1: gradient, two pixels per line -> 00 then 01; no fetches.
    vecs.push_back(mk(1, 3, 1, 1, 1, p, 8'h00, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 6, 1, 1, 1, p, 8'h01, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 7, 2, 1, 1, p, 8'h01, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 9, 2, 1, 1, p, 8'h00, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1,11, 4, 2, 1, p, 8'hFF, 1, 1, 0, 0, 0, 0));
    // Frame 2: solid 00/FF/80 with delta rotation.
    vecs.push_back(mk(2, 0, 0, 2, 1, p, 8'hFF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 3, 1, 2, 1, p, 8'h80, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(2, 4, 1, 2, 1, p, 8'h00, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(2, 5, 1, 2, 1, p, 8'hFF, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(2, 3, 2, 2, 1, p, 8'h00, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(2, 4, 2, 2, 1, p, 8'hFF, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(2, 5, 2, 2, 1, p, 8'h80, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(2,11, 4, 0, 1, p, 8'hFF, 1, 1, 0, 0, 1, 0));
    // Frame 3: stream; held pixel survives an input change; one missed fetch.
    vecs.push_back(mk(3, 2, 2, 0, 1, q, 8'h00, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(3, 3, 2, 0, 1, q, 8'hA1, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(3, 4, 2, 0, 1, r, 8'hB2, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(3, 5, 2, 0, 1, r, 8'hC3, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(3, 6, 2, 0, 0, r, 8'h00, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mk(3, 7, 2, 0, 1, r, 8'h00, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(3, 8, 2, 0, 1, r, 8'h00, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(3, 3, 3, 0, 1, r, 8'h66, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mk(3, 4, 3, 0, 1, r, 8'h44, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(3, 5, 3, 0, 1, r, 8'h55, 1, 1, 1, 0, 1, 1));
    // Underflow stays set in later frames.
    vecs.push_back(mk(4, 0, 0, 0, 1, r, 8'hFF, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(5, 4, 2, 0, 1, r, 8'h55, 1, 1, 1, 0, 1, 1));

    // After a mid-frame reset: mode input 2 is ignored for the first frame.
    rvecs.push_back(mk(0, 0, 0, 2, 1, p, 8'hFF, 0, 0, 0, 0, 0, 0));
    rvecs.push_back(mk(0, 3, 1, 2, 1, p, 8'h33, 1, 1, 1, 1, 0, 0));
    rvecs.push_back(mk(0,11, 4, 2, 1, p, 8'hFF, 1, 1, 0, 0, 1, 0));
    rvecs.push_back(mk(1, 3, 1, 2, 1, p, 8'h80, 1, 1, 1, 0, 1, 0));

    pif.pix_valid = 1'b1;
    pif.pix_rgb   = p;
    rst_n = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    chk("ready pulses frame0", 32'(rdy_cnt[0]), 32'd6);
    chk("ready pulses frame1", 32'(rdy_cnt[1]), 32'd0);
    chk("ready pulses frame2", 32'(rdy_cnt[2]), 32'd0);
    chk("ready pulses frame3", 32'(rdy_cnt[3]), 32'd6);

    // Reset in the middle of frame 5 (field=1, underflow=1).
    rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk_reset("midreset");
    rst_n = 1'b1;
    cur_h = 0; cur_v = 0; cur_fr = 0;

    foreach (rvecs[i]) run_vec(rvecs[i], $sformatf("r%0d", i));

    chk("pclk phase errors",     32'(pclk_bad), 32'd0);
    chk("ready in pclk-low half", 32'(rdy_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
